// File: rtl/decode_multi.sv
// Multi-lane decode stage: decodes a fetch group, trims it at the oldest
// mispredicted direct branch, allocates ids and branch-queue slots, and
// registers the result for the next stage.
package decode_multi_pkg;
  typedef logic [31:0] pc_t;
  typedef logic [7:0]  id_t;
  typedef logic [3:0]  bqid_t;

  typedef struct packed { logic taken; pc_t pcnext; } bp_t;
  typedef struct packed { pc_t pc; logic [31:0] data; bp_t bp; } fetch_data_t;

  typedef enum logic [2:0] {FU_ALU, FU_MEM, FU_CTRL, FU_FPU, FU_SYS} fu_t;
  typedef enum logic [4:0] {
    OP_ILLEGAL, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT,
    OP_BGE, OP_BLTU, OP_BGEU, OP_LOAD, OP_STORE, OP_ADDI, OP_ADD, OP_SUB,
    OP_ALU, OP_FP, OP_SYSTEM, OP_DRET
  } op_t;

  typedef struct packed {
    logic        valid;
    fu_t         fu;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } si_t;

  typedef struct packed { si_t si; id_t id; bqid_t bqid; logic fault; } di_t;
endpackage

module decode_multi
  import decode_multi_pkg::*;
#(
  parameter int NR_LANES = 2,
  parameter int BQ_CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  fetch_data_t         in_i [NR_LANES],
  input  logic [NR_LANES-1:0] in_i_valid,
  output logic                in_i_ready,
  output di_t                 di_o [NR_LANES],
  output logic [NR_LANES-1:0] di_o_valid,
  input  logic                di_o_ready,
  input  logic [BQ_CNT_W-1:0] bq_free_i,
  output logic [NR_LANES-1:0] bq_push_valid_o,
  input  bqid_t               bq_push_bqid_i [NR_LANES],
  input  logic                squash_valid_i,
  input  id_t                 squash_id_i,
  output logic                redirect_valid_o,
  output pc_t                 redirect_pc_o
);

  // Fixed privilege context: M-mode, FP unit enabled (Initial), no traps armed.
  localparam logic [1:0] PRIV_M     = 2'b11;
  localparam logic [1:0] PRIV_MODE  = PRIV_M;
  localparam logic [1:0] FS_OFF     = 2'b00;
  localparam logic [1:0] FS_STATE   = 2'b01;
  localparam logic       DEBUG_MODE = 1'b0;

  function automatic si_t static_decoder(input logic [31:0] d);
    si_t s;
    s       = '0;
    s.valid = (d[1:0] == 2'b11);
    s.rd    = d[11:7];
    s.rs1   = d[19:15];
    s.rs2   = d[24:20];
    s.fu    = FU_ALU;
    s.op    = OP_ILLEGAL;
    case (d[6:0])
      7'b0110111: begin s.op = OP_LUI;   s.imm = {d[31:12], 12'b0}; end
      7'b0010111: begin s.op = OP_AUIPC; s.imm = {d[31:12], 12'b0}; end
      7'b1101111: begin
        s.op = OP_JAL; s.fu = FU_CTRL;
        s.imm = {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
      end
      7'b1100111: if (d[14:12] == 3'b000) begin
        s.op = OP_JALR; s.fu = FU_CTRL; s.imm = {{20{d[31]}}, d[31:20]};
      end
      7'b1100011: begin
        s.imm = {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
        s.fu  = FU_CTRL;
        case (d[14:12])
          3'b000:  s.op = OP_BEQ;
          3'b001:  s.op = OP_BNE;
          3'b100:  s.op = OP_BLT;
          3'b101:  s.op = OP_BGE;
          3'b110:  s.op = OP_BLTU;
          3'b111:  s.op = OP_BGEU;
          default: s.fu = FU_ALU;
        endcase
      end
      7'b0000011: begin s.op = OP_LOAD;  s.fu = FU_MEM; s.imm = {{20{d[31]}}, d[31:20]}; end
      7'b0100011: begin s.op = OP_STORE; s.fu = FU_MEM; s.imm = {{20{d[31]}}, d[31:25], d[11:7]}; end
      7'b0010011: begin
        s.op  = (d[14:12] == 3'b000) ? OP_ADDI : OP_ALU;
        s.imm = {{20{d[31]}}, d[31:20]};
      end
      7'b0110011: begin
        if (d[14:12] == 3'b000 && d[31:25] == 7'b0000000)      s.op = OP_ADD;
        else if (d[14:12] == 3'b000 && d[31:25] == 7'b0100000) s.op = OP_SUB;
        else                                                   s.op = OP_ALU;
      end
      7'b0000111, 7'b0100111, 7'b1010011: begin s.op = OP_FP; s.fu = FU_FPU; end
      7'b1110011: begin
        s.fu = FU_SYS;
        s.op = (d == 32'h7b200073) ? OP_DRET : OP_SYSTEM;
      end
      default: s.op = OP_ILLEGAL;
    endcase
    return s;
  endfunction

  function automatic logic dynamic_decoder_fault(input si_t s);
    return (s.op == OP_ILLEGAL) ||
           (s.fu == FU_FPU && FS_STATE == FS_OFF) ||
           (s.op == OP_DRET && !DEBUG_MODE) ||
           (s.op == OP_SYSTEM && PRIV_MODE != PRIV_M);
  endfunction

  id_t                 id_q;
  si_t                 si_c   [NR_LANES];
  pc_t                 tgt_c  [NR_LANES];
  bqid_t               bqid_c [NR_LANES];
  logic [NR_LANES-1:0] si_ok, is_br, is_dir, mp, keep;
  int                  kept_cnt, kept_br;
  logic                older_mp, redir_hit, accept, br_fits;
  pc_t                 redir_tgt;

  // Per-lane decode, misprediction detection and trimming at the oldest mispredict
  always_comb begin
    older_mp  = 1'b0;
    kept_cnt  = 0;
    kept_br   = 0;
    redir_hit = 1'b0;
    redir_tgt = '0;
    for (int k = 0; k < NR_LANES; k++) begin
      si_c[k]   = static_decoder(in_i[k].data);
      tgt_c[k]  = in_i[k].pc + si_c[k].imm;
      si_ok[k]  = si_c[k].valid;
      is_br[k]  = (si_c[k].fu == FU_CTRL);
      is_dir[k] = si_c[k].op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL};
      mp[k]     = in_i_valid[k] &&
                  ((is_dir[k] && in_i[k].bp.taken && in_i[k].bp.pcnext != tgt_c[k]) ||
                   (si_c[k].op == OP_JAL && !in_i[k].bp.taken));
      keep[k]   = in_i_valid[k] && !older_mp;
      older_mp  = older_mp || mp[k];
      if (keep[k])             kept_cnt = kept_cnt + 1;
      if (keep[k] && is_br[k]) kept_br  = kept_br + 1;
      if (keep[k] && mp[k]) begin
        redir_hit = 1'b1;
        redir_tgt = tgt_c[k];
      end
    end
  end

  assign br_fits    = (kept_br <= int'(bq_free_i));
  assign in_i_ready = !rst && !squash_valid_i && (!(|di_o_valid) || di_o_ready) && br_fits;
  assign accept     = (|in_i_valid) && in_i_ready;

  // Branch-queue pushes: the n-th kept branch takes the n-th offered bqid
  always_comb begin
    int pos;
    pos = 0;
    for (int k = 0; k < NR_LANES; k++) begin
      bq_push_valid_o[k] = accept && keep[k] && is_br[k];
      bqid_c[k]          = '0;
      if (keep[k] && is_br[k]) begin
        for (int j = 0; j < NR_LANES; j++)
          if (j == pos) bqid_c[k] = bq_push_bqid_i[j];
        pos = pos + 1;
      end
    end
  end

  // Output register p0: load on accept, drain on ready, clear on squash or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      di_o_valid       <= '0;
      id_q             <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      for (int k = 0; k < NR_LANES; k++) di_o[k] <= '0;
    end else if (squash_valid_i) begin
      di_o_valid       <= '0;
      redirect_valid_o <= 1'b0;
      id_q             <= squash_id_i + id_t'(1);
    end else begin
      redirect_valid_o <= accept && redir_hit;
      if (accept) begin
        di_o_valid <= keep;
        id_q       <= id_q + id_t'(kept_cnt);
        if (redir_hit) redirect_pc_o <= redir_tgt;
        for (int k = 0; k < NR_LANES; k++) begin
          if (keep[k]) begin
            di_o[k].si    <= si_c[k];
            di_o[k].id    <= id_q + id_t'(k);
            di_o[k].bqid  <= bqid_c[k];
            di_o[k].fault <= dynamic_decoder_fault(si_c[k]);
          end else begin
            di_o[k] <= '0;
          end
        end
      end else if (di_o_ready) begin
        di_o_valid <= '0;
      end
    end
  end

  logic [NR_LANES-1:0] vld_inc;
  assign vld_inc = in_i_valid + NR_LANES'(1);

  a_contiguous: assert property (@(posedge clk) disable iff (rst)
    ((in_i_valid & vld_inc) == '0));
  a_si_valid: assert property (@(posedge clk) disable iff (rst)
    ((in_i_valid & ~si_ok) == '0));

endmodule

// File: tb/tb_decode_multi.sv
// Directed bench for decode_multi: vector table for single-group behaviour,
// hand sequences for stall, squash, id wrap and reset.
module tb_decode_multi;
  import decode_multi_pkg::*;

  localparam int NL = 2;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  fetch_data_t   in_i [NL];
  logic [NL-1:0] in_i_valid;
  logic          in_i_ready;
  di_t           di_o [NL];
  logic [NL-1:0] di_o_valid;
  logic          di_o_ready;
  logic [BW-1:0] bq_free_i;
  logic [NL-1:0] bq_push_valid_o;
  bqid_t         bq_push_bqid_i [NL];
  logic          squash_valid_i;
  id_t           squash_id_i;
  logic          redirect_valid_o;
  pc_t           redirect_pc_o;

  decode_multi #(.NR_LANES(NL), .BQ_CNT_W(BW)) dut (
    .clk(clk), .rst(rst), .in_i(in_i), .in_i_valid(in_i_valid), .in_i_ready(in_i_ready),
    .di_o(di_o), .di_o_valid(di_o_valid), .di_o_ready(di_o_ready), .bq_free_i(bq_free_i),
    .bq_push_valid_o(bq_push_valid_o), .bq_push_bqid_i(bq_push_bqid_i),
    .squash_valid_i(squash_valid_i), .squash_id_i(squash_id_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_add(input logic [4:0] rd);
    return {7'b0, 5'd3, 5'd2, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi();
    return {12'd5, 5'd1, 3'b000, 5'd2, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  typedef struct {
    logic [31:0] i0, i1;
    pc_t         pc0, pc1;
    logic        tk0, tk1;
    pc_t         nx0, nx1;
    logic [1:0]  vld;
    logic [3:0]  free;
    logic        e_rdy;
    logic [1:0]  e_push;
    logic [1:0]  e_vld;
    id_t         e_id0, e_id1;
    bqid_t       e_bq0, e_bq1;
    logic        e_redir;
    pc_t         e_rpc;
  } vec_t;

  vec_t tv [13];

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input pc_t pc0, input pc_t pc1,
                       input logic tk0, input pc_t nx0, input logic tk1, input pc_t nx1,
                       input logic [1:0] vld);
    in_i[0].data = i0; in_i[0].pc = pc0; in_i[0].bp.taken = tk0; in_i[0].bp.pcnext = nx0;
    in_i[1].data = i1; in_i[1].pc = pc1; in_i[1].bp.taken = tk1; in_i[1].bp.pcnext = nx1;
    in_i_valid = vld;
  endtask

  task automatic drive_alu2(input pc_t pc);
    drive(enc_add(5'd1), enc_add(5'd4), pc, pc + 32'd4, 1'b0, '0, 1'b0, '0, 2'b11);
  endtask

  initial begin
    logic [31:0] add1, add4, addi;
    add1 = enc_add(5'd1);
    add4 = enc_add(5'd4);
    addi = enc_addi();
    //        i0                   i1                   pc0        pc1        tk0 tk1 nx0        nx1        vld    free rdy push   vld    id0 id1 bq0 bq1 redir rpc
    tv[0]  = '{add1,               add4,                32'h100,   32'h104,   0,  0,  32'h0,     32'h0,     2'b11, 4, 1, 2'b00, 2'b11, 0,  1,  0,  0,  0, 32'h0};
    tv[1]  = '{add1,               add4,                32'h108,   32'h10c,   0,  0,  32'h0,     32'h0,     2'b11, 4, 1, 2'b00, 2'b11, 2,  3,  0,  0,  0, 32'h0};
    tv[2]  = '{addi,               add4,                32'h110,   32'h114,   0,  0,  32'h0,     32'h0,     2'b01, 4, 1, 2'b00, 2'b01, 4,  0,  0,  0,  0, 32'h0};
    tv[3]  = '{add1,               add4,                32'h114,   32'h118,   0,  0,  32'h0,     32'h0,     2'b11, 4, 1, 2'b00, 2'b11, 5,  6,  0,  0,  0, 32'h0};
    tv[4]  = '{enc_b(3'b000, 13'd16), add4,             32'h1000,  32'h1004,  1,  0,  32'h1004,  32'h0,     2'b11, 4, 1, 2'b01, 2'b01, 7,  0,  3,  0,  1, 32'h1010};
    tv[5]  = '{add1,               add4,                32'h1010,  32'h1014,  0,  0,  32'h0,     32'h0,     2'b11, 4, 1, 2'b00, 2'b11, 8,  9,  0,  0,  0, 32'h0};
    tv[6]  = '{enc_b(3'b001, 13'd8), enc_b(3'b001, 13'h1ff8), 32'h1100, 32'h1104, 0, 0, 32'h0, 32'h0,   2'b11, 1, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0, 32'h0};
    tv[7]  = '{enc_b(3'b001, 13'd8), enc_b(3'b001, 13'h1ff8), 32'h1100, 32'h1104, 0, 0, 32'h0, 32'h0,   2'b11, 2, 1, 2'b11, 2'b11, 10, 11, 3,  9,  0, 32'h0};
    tv[8]  = '{add1,               enc_j(21'h100),      32'h3000,  32'h3004,  0,  0,  32'h0,     32'h0,     2'b11, 4, 1, 2'b10, 2'b11, 12, 13, 0,  3,  1, 32'h3104};
    tv[9]  = '{enc_j(21'h40),      add4,                32'h4000,  32'h4040,  1,  0,  32'h4040,  32'h0,     2'b11, 4, 1, 2'b01, 2'b11, 14, 15, 3,  0,  0, 32'h0};
    tv[10] = '{add1,               add4,                32'h4044,  32'h4048,  0,  0,  32'h0,     32'h0,     2'b00, 4, 1, 2'b00, 2'b00, 0,  0,  0,  0,  0, 32'h0};
    tv[11] = '{enc_b(3'b000, 13'h20), enc_b(3'b001, 13'h1ff8), 32'h5000, 32'h5004, 1, 1, 32'h5020, 32'h5008, 2'b11, 4, 1, 2'b11, 2'b11, 16, 17, 3, 9, 1, 32'h4ffc};
    tv[12] = '{enc_j(21'h800),     add4,                32'h6000,  32'h6004,  0,  0,  32'h0,     32'h0,     2'b11, 4, 1, 2'b01, 2'b01, 18, 0,  3,  0,  1, 32'h6800};

    // Reset, with a valid branch group offered
    rst = 1'b1; squash_valid_i = 1'b0; squash_id_i = '0; di_o_ready = 1'b1; bq_free_i = 4'd4;
    bq_push_bqid_i[0] = 4'd3; bq_push_bqid_i[1] = 4'd9;
    drive(enc_b(3'b000, 13'd16), add4, 32'h200, 32'h204, 1'b0, '0, 1'b0, '0, 2'b11);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", in_i_ready, 0);
    chk("rst_push", bq_push_valid_o, 0);
    chk("rst_vld", di_o_valid, 0);
    chk("rst_redir", redirect_valid_o, 0);
    chk("rst_rpc", redirect_pc_o, 0);
    chk("rst_id0", di_o[0].id, 0);
    rst = 1'b0;
    in_i_valid = 2'b00;

    // Table-driven single-group vectors
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].i0, tv[i].i1, tv[i].pc0, tv[i].pc1, tv[i].tk0, tv[i].nx0, tv[i].tk1, tv[i].nx1, tv[i].vld);
      bq_free_i = tv[i].free;
      #1;
      chk($sformatf("v%0d_ready", i), in_i_ready, tv[i].e_rdy);
      chk($sformatf("v%0d_push", i), bq_push_valid_o, tv[i].e_push);
      @(negedge clk);
      chk($sformatf("v%0d_vld", i), di_o_valid, tv[i].e_vld);
      if (tv[i].e_vld[0]) begin
        chk($sformatf("v%0d_id0", i), di_o[0].id, tv[i].e_id0);
        chk($sformatf("v%0d_bq0", i), di_o[0].bqid, tv[i].e_bq0);
      end
      if (tv[i].e_vld[1]) begin
        chk($sformatf("v%0d_id1", i), di_o[1].id, tv[i].e_id1);
        chk($sformatf("v%0d_bq1", i), di_o[1].bqid, tv[i].e_bq1);
      end
      chk($sformatf("v%0d_redir", i), redirect_valid_o, tv[i].e_redir);
      if (tv[i].e_redir) chk($sformatf("v%0d_rpc", i), redirect_pc_o, tv[i].e_rpc);
    end
    bq_free_i = 4'd4;

    // Stall: group held while next stage is not ready
    drive_alu2(32'h7000);
    #1 chk("hold_acc_ready", in_i_ready, 1);
    @(negedge clk);
    chk("hold_id0", di_o[0].id, 19);
    chk("hold_id1", di_o[1].id, 20);
    chk("hold_redir_pulse", redirect_valid_o, 0);
    di_o_ready = 1'b0;
    drive_alu2(32'h7008);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_ready", c), in_i_ready, 0);
      @(negedge clk);
      chk($sformatf("hold%0d_vld", c), di_o_valid, 2'b11);
      chk($sformatf("hold%0d_id0", c), di_o[0].id, 19);
      chk($sformatf("hold%0d_id1", c), di_o[1].id, 20);
    end
    di_o_ready = 1'b1;
    #1 chk("release_ready", in_i_ready, 1);
    @(negedge clk);
    chk("release_vld", di_o_valid, 2'b11);
    chk("release_id0", di_o[0].id, 21);
    chk("release_id1", di_o[1].id, 22);

    // Squash while a group is held and a new one is offered
    di_o_ready = 1'b0;
    squash_valid_i = 1'b1; squash_id_i = 8'h20;
    drive(enc_b(3'b000, 13'd8), add4, 32'h7100, 32'h7104, 1'b0, '0, 1'b0, '0, 2'b11);
    #1;
    chk("squash_ready", in_i_ready, 0);
    chk("squash_push", bq_push_valid_o, 0);
    @(negedge clk);
    chk("squash_vld", di_o_valid, 0);
    chk("squash_redir", redirect_valid_o, 0);
    squash_valid_i = 1'b0; di_o_ready = 1'b1;
    drive_alu2(32'h7200);
    @(negedge clk);
    chk("post_squash_id0", di_o[0].id, 8'h21);
    chk("post_squash_id1", di_o[1].id, 8'h22);

    // Id wrap
    squash_valid_i = 1'b1; squash_id_i = 8'hfe; in_i_valid = 2'b00;
    @(negedge clk);
    squash_valid_i = 1'b0;
    drive_alu2(32'h7300);
    @(negedge clk);
    chk("wrap_id0", di_o[0].id, 8'hff);
    chk("wrap_id1", di_o[1].id, 8'h00);
    in_i_valid = 2'b01;
    @(negedge clk);
    chk("wrap_next_vld", di_o_valid, 2'b01);
    chk("wrap_next_id0", di_o[0].id, 8'h01);

    // Mid-operation reset discards the held group
    drive_alu2(32'h7400);
    @(negedge clk);
    chk("pre_rst_id0", di_o[0].id, 2);
    di_o_ready = 1'b0; rst = 1'b1;
    drive(enc_b(3'b000, 13'd8), enc_b(3'b001, 13'd8), 32'h7500, 32'h7504, 1'b0, '0, 1'b0, '0, 2'b11);
    #1;
    chk("mid_rst_ready", in_i_ready, 0);
    chk("mid_rst_push", bq_push_valid_o, 0);
    @(negedge clk);
    chk("mid_rst_vld", di_o_valid, 0);
    chk("mid_rst_rpc", redirect_pc_o, 0);
    rst = 1'b0; di_o_ready = 1'b1;
    drive_alu2(32'h7600);
    @(negedge clk);
    chk("after_rst_id0", di_o[0].id, 0);
    chk("after_rst_id1", di_o[1].id, 1);
    in_i_valid = 2'b00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
